// File: rtl/unidad_ejecucion.sv
// Multi-cycle execution unit: reads two registers, runs an ALU op or a 32-step
// shift-add multiply, then writes the result back in a single ESCR cycle.
module unidad_ejecucion #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inicio,
  input  logic [2:0]        op,
  input  logic [DIR_W-1:0]  rs,
  input  logic [DIR_W-1:0]  rt,
  input  logic [DIR_W-1:0]  rd,
  input  logic [DATA_W-1:0] datosIn1,
  input  logic [DATA_W-1:0] datosIn2,
  output logic [DIR_W-1:0]  dirLec1,
  output logic [DIR_W-1:0]  dirLec2,
  output logic [DIR_W-1:0]  dirEsc,
  output logic [DATA_W-1:0] datos,
  output logic              we,
  output logic              ocupado,
  output logic              listo,
  output logic              cero
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [2:0]  OpMul = 3'b101;

  typedef enum logic [2:0] {StIdle, StLeer, StEjec, StMult, StEscr} estado_t;

  estado_t             estado_q;
  logic [2:0]          op_q;
  logic [DIR_W-1:0]    rd_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [DATA_W-1:0]   mcand_q, mplier_q, acc_q;
  logic [CntW-1:0]     cnt_q;

  logic [DATA_W-1:0]   alu_res, acc_sum, res_fin;
  logic                fin;

  always_comb begin
    alu_res = '0;
    case (op_q)
      3'b000:  alu_res = a_q + b_q;
      3'b001:  alu_res = a_q - b_q;
      3'b010:  alu_res = a_q & b_q;
      3'b011:  alu_res = a_q | b_q;
      3'b100:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      3'b110:  alu_res = ~(a_q | b_q);
      default: alu_res = '0;
    endcase
  end

  // One shift-add step; the final step's sum is the product written in ESCR.
  assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign res_fin = (estado_q == StMult) ? acc_sum : alu_res;
  assign fin     = ((estado_q == StEjec) && (op_q != OpMul)) ||
                   ((estado_q == StMult) && (cnt_q == CntW'(DATA_W - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= StIdle;
      op_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dirLec1  <= '0;
      dirLec2  <= '0;
      dirEsc   <= '0;
      datos    <= '0;
      we       <= 1'b0;
      ocupado  <= 1'b0;
      listo    <= 1'b0;
      cero     <= 1'b0;
    end else begin
      we    <= 1'b0;
      listo <= 1'b0;
      if (fin) begin
        dirEsc   <= rd_q;
        datos    <= res_fin;
        we       <= (rd_q != '0);
        listo    <= 1'b1;
        cero     <= (res_fin == '0);
        estado_q <= StEscr;
      end
      case (estado_q)
        StIdle: begin
          if (inicio) begin
            op_q     <= op;
            rd_q     <= rd;
            dirLec1  <= rs;
            dirLec2  <= rt;
            ocupado  <= 1'b1;
            estado_q <= StLeer;
          end
        end
        StLeer: begin
          a_q      <= datosIn1;
          b_q      <= datosIn2;
          estado_q <= StEjec;
        end
        StEjec: begin
          if (op_q == OpMul) begin
            mcand_q  <= a_q;
            mplier_q <= b_q;
            acc_q    <= '0;
            cnt_q    <= '0;
            estado_q <= StMult;
          end
        end
        StMult: begin
          acc_q    <= acc_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
        end
        StEscr: begin
          ocupado  <= 1'b0;
          estado_q <= StIdle;
        end
        default: estado_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/unidad_ejecucion.md
UNIDAD_EJECUCION -- requirements
Module: unidad_ejecucion

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width.
REQ-002 Parameter: DIR_W, 5, register address width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: inicio  input  1  start request, sampled only in IDLE.
REQ-006 Port: op  input  3  operation code, captured with inicio.
REQ-007 Port: rs  input  DIR_W  source register 1, captured with inicio.
REQ-008 Port: rt  input  DIR_W  source register 2, captured with inicio.
REQ-009 Port: rd  input  DIR_W  destination register, captured with inicio.
REQ-010 Port: datosIn1  input  DATA_W  register-file read data for dirLec1 (combinational read).
REQ-011 Port: datosIn2  input  DATA_W  register-file read data for dirLec2.
REQ-012 Port: dirLec1  output  DIR_W  read address 1 to register file.
REQ-013 Port: dirLec2  output  DIR_W  read address 2 to register file.
REQ-014 Port: dirEsc  output  DIR_W  write address to register file.
REQ-015 Port: datos  output  DATA_W  write data to register file.
REQ-016 Port: we  output  1  register-file write enable; 0 = read mode.
REQ-017 Port: ocupado  output  1  high in every state except IDLE.
REQ-018 Port: listo  output  1  one-cycle completion pulse.
REQ-019 Port: cero  output  1  last written result equal to zero; held until next completion.

Function
REQ-020 States SHALL be IDLE, LEER, EJEC, MULT, ESCR; all outputs registered.
REQ-021 IDLE: inicio=1 SHALL capture op/rs/rt/rd and go to LEER next edge; inicio=0 stays IDLE.
REQ-022 LEER: dirLec1=rs, dirLec2=rt, we=0; datosIn1/datosIn2 SHALL be captured at the end of LEER; go to EJEC.
REQ-023 EJEC: op 000 add, 001 sub (A-B), 010 and, 011 or, 100 signed slt (1/0), 110 nor, 111 result 0; all arithmetic modulo 2^DATA_W, no overflow flag; go to ESCR.
REQ-024 EJEC with op 101 SHALL go to MULT; MULT SHALL run an iterative shift-add multiply for exactly 32 cycles, producing the low 32 bits of the unsigned product, then go to ESCR.
REQ-025 ESCR: exactly one cycle with dirEsc=rd, datos=result, listo=1, cero updated; we=1 unless rd=0, in which case we=0 (register 0 never written); go to IDLE.
REQ-026 Latency: inicio sampled at edge N -> ESCR during cycle N+3 for non-multiply ops, N+35 for multiply.
REQ-027 inicio while ocupado=1 SHALL be ignored; no queuing.
REQ-028 we SHALL be 0 in every state except ESCR; dirLec1/dirLec2/dirEsc/datos hold last values outside their active states.
REQ-029 inicio asserted in the IDLE cycle immediately after ESCR SHALL be accepted (back-to-back operation, 4-cycle throughput).

Reset
REQ-030 rst=1 at an edge SHALL force IDLE and dirLec1=0, dirLec2=0, dirEsc=0, datos=0, we=0, ocupado=0, listo=0, cero=0, multiply counter and accumulators 0.
REQ-031 rst has priority over inicio; rst during LEER/EJEC/MULT/ESCR SHALL abort with no write issued after that edge.

Verification
REQ-032 Reg file R1=5, R2=7; inicio op=000 rs=1 rt=2 rd=3 -> we=1 one cycle, dirEsc=3, datos=12, listo=1, cero=0, 3 cycles after accept.
REQ-033 R1=0xFFFFFFFF, R2=1; op=000 rd=4 -> datos=0x00000000, cero=1; op=100 with R1=-1, R2=1 -> datos=1.
REQ-034 R1=0x00010001, R2=0x00010000; op=101 rd=5 -> ocupado high 35 cycles, datos=0x00010000 (low 32 bits), we=1 once.
REQ-035 op=000 rd=0 -> listo=1, we=0 throughout; second inicio pulsed during EJEC -> ignored, only one listo.
REQ-036 rst asserted at MULT cycle 10 -> next cycle IDLE, all outputs 0, no we pulse; fresh inicio then completes normally.
REQ-037 Back-to-back: inicio held high continuously with op=010 -> listo pulses every 4 cycles, we never high two consecutive cycles.
